// File: rtl/br_rs_sched_pkg.sv
// rtl/br_rs_sched_pkg.sv - shared constants, branch funct3 codes and CDB tag-match helper
package br_rs_sched_pkg;

    localparam int ROB_SIZE_BIT = 4;
    localparam int RS_SIZE_DEF  = 4;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_op_e;

    // True when a pending operand is produced by the tag on the CDB this cycle.
    function automatic logic tag_hit(
        input logic                    cdb_valid,
        input logic                    pending,
        input logic [ROB_SIZE_BIT-1:0] q,
        input logic [ROB_SIZE_BIT-1:0] cdb_rob
    );
        return cdb_valid && pending && (q == cdb_rob);
    endfunction

endpackage

// File: rtl/br_rs_pick.sv
// rtl/br_rs_pick.sv - combinational oldest-ready selector (minimum rank among ready entries)
module br_rs_pick #(
    parameter int N  = 4,
    parameter int RW = 2
) (
    input  logic [N-1:0]         ready,
    input  logic [N-1:0][RW-1:0] rank,
    output logic                 grant_valid,
    output logic [RW-1:0]        grant_idx,
    output logic [RW-1:0]        grant_rank
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_rank  = '0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && (!grant_valid || (rank[i] < grant_rank))) begin
                grant_valid = 1'b1;
                grant_idx   = RW'(i);
                grant_rank  = rank[i];
            end
        end
    end

endmodule

// File: rtl/br_rs_sched.sv
// rtl/br_rs_sched.sv - branch reservation station with CDB wakeup and oldest-ready issue
module br_rs_sched
    import br_rs_sched_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic                    disp_valid,
    input  logic [2:0]              disp_op,
    input  logic [31:0]             disp_vj,
    input  logic [31:0]             disp_vk,
    input  logic [ROB_SIZE_BIT-1:0] disp_qj,
    input  logic [ROB_SIZE_BIT-1:0] disp_qk,
    input  logic                    disp_qj_busy,
    input  logic                    disp_qk_busy,
    input  logic [11:0]             disp_imm,
    input  logic [31:0]             disp_pc,
    input  logic [ROB_SIZE_BIT-1:0] disp_rob,
    input  logic                    cdb_valid,
    input  logic [ROB_SIZE_BIT-1:0] cdb_rob,
    input  logic [31:0]             cdb_value,
    output logic                    full_out,
    output logic                    alu_new,
    output logic [2:0]              alu_op,
    output logic [31:0]             alu_vi,
    output logic [31:0]             alu_vj,
    output logic [11:0]             alu_imm,
    output logic [31:0]             alu_pc,
    output logic [ROB_SIZE_BIT-1:0] alu_rob
);

    localparam int RW = $clog2(RS_SIZE);
    localparam int CW = RW + 1;

    logic [RS_SIZE-1:0]         busy, qj_busy, qk_busy;
    logic [RS_SIZE-1:0][RW-1:0] rank;
    logic [2:0]                 op  [RS_SIZE];
    logic [31:0]                vj  [RS_SIZE];
    logic [31:0]                vk  [RS_SIZE];
    logic [ROB_SIZE_BIT-1:0]    qj  [RS_SIZE];
    logic [ROB_SIZE_BIT-1:0]    qk  [RS_SIZE];
    logic [11:0]                imm [RS_SIZE];
    logic [31:0]                pc  [RS_SIZE];
    logic [ROB_SIZE_BIT-1:0]    rob [RS_SIZE];

    logic [CW-1:0]      count;
    logic [RS_SIZE-1:0] ready, j_wake, k_wake;
    logic [RW-1:0]      free_idx, disp_rank;
    logic               grant_valid, do_disp, disp_j_hit, disp_k_hit;
    logic [RW-1:0]      grant_idx, grant_rank;

    always_comb begin
        count    = '0;
        free_idx = '0;
        ready    = '0;
        j_wake   = '0;
        k_wake   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            count     = count + CW'(busy[i]);
            ready[i]  = busy[i] && !qj_busy[i] && !qk_busy[i];
            j_wake[i] = busy[i] && tag_hit(cdb_valid, qj_busy[i], qj[i], cdb_rob);
            k_wake[i] = busy[i] && tag_hit(cdb_valid, qk_busy[i], qk[i], cdb_rob);
            if (!busy[i]) free_idx = RW'(i);
        end
    end

    assign full_out   = (count == CW'(RS_SIZE));
    assign do_disp    = disp_valid && !full_out;
    assign disp_j_hit = tag_hit(cdb_valid, disp_qj_busy, disp_qj, cdb_rob);
    assign disp_k_hit = tag_hit(cdb_valid, disp_qk_busy, disp_qk, cdb_rob);
    // A same-cycle issue closes the gap in the rank order before the newcomer lands.
    assign disp_rank  = count[RW-1:0] - RW'(grant_valid);

    br_rs_pick #(.N(RS_SIZE), .RW(RW)) u_pick (
        .ready       (ready),
        .rank        (rank),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_rank  (grant_rank)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy    <= '0;
            qj_busy <= '0;
            qk_busy <= '0;
            rank    <= '0;
            alu_new <= 1'b0;
            alu_op  <= '0;
            alu_vi  <= '0;
            alu_vj  <= '0;
            alu_imm <= '0;
            alu_pc  <= '0;
            alu_rob <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                busy    <= '0;
                alu_new <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (j_wake[i]) qj_busy[i] <= 1'b0;
                    if (k_wake[i]) qk_busy[i] <= 1'b0;
                    if (grant_valid && busy[i] && (rank[i] > grant_rank))
                        rank[i] <= rank[i] - RW'(1);
                end
                if (grant_valid) busy[grant_idx] <= 1'b0;
                if (do_disp) begin
                    busy[free_idx]    <= 1'b1;
                    qj_busy[free_idx] <= disp_qj_busy && !disp_j_hit;
                    qk_busy[free_idx] <= disp_qk_busy && !disp_k_hit;
                    rank[free_idx]    <= disp_rank;
                end
                alu_new <= grant_valid;
                if (grant_valid) begin
                    alu_op  <= op[grant_idx];
                    alu_vi  <= vj[grant_idx];
                    alu_vj  <= vk[grant_idx];
                    alu_imm <= imm[grant_idx];
                    alu_pc  <= pc[grant_idx];
                    alu_rob <= rob[grant_idx];
                end
            end
        end
    end

    // Payload carries no reset; validity is tracked solely by busy/q*_busy.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (j_wake[i]) vj[i] <= cdb_value;
                if (k_wake[i]) vk[i] <= cdb_value;
            end
            if (do_disp) begin
                op[free_idx]  <= disp_op;
                vj[free_idx]  <= disp_j_hit ? cdb_value : disp_vj;
                vk[free_idx]  <= disp_k_hit ? cdb_value : disp_vk;
                qj[free_idx]  <= disp_qj;
                qk[free_idx]  <= disp_qk;
                imm[free_idx] <= disp_imm;
                pc[free_idx]  <= disp_pc;
                rob[free_idx] <= disp_rob;
            end
        end
    end

endmodule

// File: tb/tb_br_rs_sched.sv
// tb/tb_br_rs_sched.sv - self-checking bench for br_rs_sched against an age-ordered queue model
module tb_br_rs_sched;
    import br_rs_sched_pkg::*;

    logic                    clk_in, rst_n_in, rdy_in, clear_in;
    logic                    disp_valid, disp_qj_busy, disp_qk_busy, cdb_valid;
    logic [2:0]              disp_op;
    logic [31:0]             disp_vj, disp_vk, disp_pc, cdb_value;
    logic [ROB_SIZE_BIT-1:0] disp_qj, disp_qk, disp_rob, cdb_rob;
    logic [11:0]             disp_imm;
    logic                    full_out, alu_new;
    logic [2:0]              alu_op;
    logic [31:0]             alu_vi, alu_vj, alu_pc;
    logic [11:0]             alu_imm;
    logic [ROB_SIZE_BIT-1:0] alu_rob;

    br_rs_sched #(.RS_SIZE(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_qj_busy(disp_qj_busy),
        .disp_qk_busy(disp_qk_busy), .disp_imm(disp_imm), .disp_pc(disp_pc),
        .disp_rob(disp_rob), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
        .cdb_value(cdb_value), .full_out(full_out), .alu_new(alu_new), .alu_op(alu_op),
        .alu_vi(alu_vi), .alu_vj(alu_vj), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_rob(alu_rob)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]              op;
        logic [31:0]             vj, vk, pc;
        logic [ROB_SIZE_BIT-1:0] qj, qk, rob;
        bit                      qjb, qkb;
        logic [11:0]             imm;
    } ent_t;

    ent_t mq[$];
    logic                    exp_new;
    logic [2:0]              exp_op;
    logic [31:0]             exp_vi, exp_vj, exp_pc;
    logic [11:0]             exp_imm;
    logic [ROB_SIZE_BIT-1:0] exp_rob;

    task automatic model_reset();
        mq.delete();
        exp_new = 1'b0; exp_op = '0; exp_vi = '0; exp_vj = '0;
        exp_pc = '0; exp_imm = '0; exp_rob = '0;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; clear_in = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0;
        disp_op = '0; disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0;
        disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_imm = '0; disp_pc = '0;
        disp_rob = '0; cdb_rob = '0; cdb_value = '0;
    endtask

    task automatic set_disp(input logic [2:0] op, input logic [31:0] vj, vk,
                            input logic [3:0] qj, input logic qjb,
                            input logic [3:0] qk, input logic qkb, input logic [3:0] rob);
        disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk;
        disp_qj = qj; disp_qj_busy = qjb; disp_qk = qk; disp_qk_busy = qkb;
        disp_rob = rob; disp_imm = 12'($urandom); disp_pc = $urandom;
    endtask

    // Advance one edge and apply the scheduling rules to the age-ordered queue.
    task automatic step();
        int   pick;
        bit   was_full;
        ent_t e;
        ent_t w;
        @(posedge clk_in);
        if (rdy_in) begin
            if (clear_in) begin
                mq.delete();
                exp_new = 1'b0;
            end else begin
                was_full = (mq.size() == 4);
                pick = -1;
                foreach (mq[i]) if (pick < 0 && !mq[i].qjb && !mq[i].qkb) pick = i;
                if (pick >= 0) begin
                    e = mq[pick];
                    exp_new = 1'b1; exp_op = e.op; exp_vi = e.vj; exp_vj = e.vk;
                    exp_imm = e.imm; exp_pc = e.pc; exp_rob = e.rob;
                    mq.delete(pick);
                end else begin
                    exp_new = 1'b0;
                end
                foreach (mq[i]) begin
                    w = mq[i];
                    if (cdb_valid && w.qjb && w.qj == cdb_rob) begin w.vj = cdb_value; w.qjb = 0; end
                    if (cdb_valid && w.qkb && w.qk == cdb_rob) begin w.vk = cdb_value; w.qkb = 0; end
                    mq[i] = w;
                end
                if (disp_valid && !was_full) begin
                    e.op = disp_op; e.vj = disp_vj; e.vk = disp_vk; e.qj = disp_qj;
                    e.qk = disp_qk; e.qjb = disp_qj_busy; e.qkb = disp_qk_busy;
                    e.imm = disp_imm; e.pc = disp_pc; e.rob = disp_rob;
                    if (cdb_valid && e.qjb && e.qj == cdb_rob) begin e.vj = cdb_value; e.qjb = 0; end
                    if (cdb_valid && e.qkb && e.qk == cdb_rob) begin e.vk = cdb_value; e.qkb = 0; end
                    mq.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n_in = 1'b0;
        @(posedge clk_in);
        #1;
        model_reset();
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n_in = 1'b0;
        @(posedge clk_in);
        #1;
        checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full_out); end
        checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL reset_new got=%0b exp=0", alu_new); end
        checks++; if (alu_rob !== '0 || alu_vi !== '0 || alu_pc !== '0) begin failures++; $display("FAIL reset_alu rob=%0h vi=%0h pc=%0h exp=0", alu_rob, alu_vi, alu_pc); end
        model_reset();
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_disp(BEQ, 1, 1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd1); step();
        set_disp(BNE, 2, 2, 4'd0, 1'b0, 4'd5, 1'b1, 4'd2); step();
        set_disp(BLT, 3, 4, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3); step();
        set_disp(BGE, 4, 4, 4'd5, 1'b1, 4'd0, 1'b0, 4'd4); step();
        disp_valid = 1'b0;
        checks++; if (alu_new !== 1'b1 || alu_rob !== 4'd3) begin failures++; $display("FAIL mid_pre_issue new=%0b rob=%0d exp=1/3", alu_new, alu_rob); end
        #3 rst_n_in = 1'b0;
        #1;
        checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL mid_async_new got=%0b exp=0", alu_new); end
        checks++; if (full_out !== 1'b0 || alu_rob !== '0) begin failures++; $display("FAIL mid_async_state full=%0b rob=%0d exp=0/0", full_out, alu_rob); end
        @(posedge clk_in);
        #1;
        model_reset();
        rst_n_in = 1'b1;
        cdb_valid = 1'b1; cdb_rob = 4'd5; cdb_value = 32'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL mid_no_issue cycle=%0d got=%0b exp=0", i, alu_new); end
        end
        cdb_valid = 1'b0;
    endtask

    task automatic test_beq_ready();
        do_reset();
        set_disp(BEQ, 32'd5, 32'd5, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2);
        step();
        disp_valid = 1'b0;
        checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL beq_early got=%0b exp=0", alu_new); end
        step();
        checks++; if (alu_new !== 1'b1 || alu_op !== 3'b000) begin failures++; $display("FAIL beq_issue new=%0b op=%0b exp=1/000", alu_new, alu_op); end
        checks++; if (alu_vi !== 32'd5 || alu_vj !== 32'd5 || alu_rob !== 4'd2) begin failures++; $display("FAIL beq_fields vi=%0d vj=%0d rob=%0d exp=5/5/2", alu_vi, alu_vj, alu_rob); end
        step();
        checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL beq_pulse got=%0b exp=0", alu_new); end
    endtask

    task automatic test_cdb_wakeup();
        do_reset();
        set_disp(BLT, 32'd0, 32'd10, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4);
        step();
        disp_valid = 1'b0;
        step();
        checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL wake_wait got=%0b exp=0", alu_new); end
        cdb_valid = 1'b1; cdb_rob = 4'd3; cdb_value = 32'hFFFF_FFFF;
        step();
        cdb_valid = 1'b0;
        checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL wake_cdb_edge got=%0b exp=0", alu_new); end
        step();
        checks++; if (alu_new !== 1'b1 || alu_vi !== 32'hFFFF_FFFF || alu_op !== 3'b100) begin failures++; $display("FAIL wake_issue new=%0b vi=%0h op=%0b exp=1/ffffffff/100", alu_new, alu_vi, alu_op); end
    endtask

    task automatic test_cdb_bypass();
        do_reset();
        set_disp(BNE, 32'd9, 32'd0, 4'd0, 1'b0, 4'd7, 1'b1, 4'd6);
        cdb_valid = 1'b1; cdb_rob = 4'd7; cdb_value = 32'h1234_5678;
        step();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        step();
        checks++; if (alu_new !== 1'b1 || alu_vj !== 32'h1234_5678 || alu_rob !== 4'd6) begin failures++; $display("FAIL bypass new=%0b vj=%0h rob=%0d exp=1/12345678/6", alu_new, alu_vj, alu_rob); end
    endtask

    task automatic test_full_order();
        do_reset();
        set_disp(BEQ,  32'd0, 32'd1, 4'd8,  1'b1, 4'd0, 1'b0, 4'd1); step();
        set_disp(BNE,  32'd2, 32'd0, 4'd0,  1'b0, 4'd8, 1'b1, 4'd2); step();
        set_disp(BLTU, 32'd0, 32'd3, 4'd10, 1'b1, 4'd0, 1'b0, 4'd3); step();
        set_disp(BGEU, 32'd0, 32'd4, 4'd10, 1'b1, 4'd0, 1'b0, 4'd4); step();
        checks++; if (full_out !== 1'b1 || alu_new !== 1'b0) begin failures++; $display("FAIL full_set full=%0b new=%0b exp=1/0", full_out, alu_new); end
        set_disp(BEQ, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5);
        cdb_valid = 1'b1; cdb_rob = 4'd10; cdb_value = 32'hA;
        step();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        checks++; if (full_out !== 1'b1 || alu_new !== 1'b0) begin failures++; $display("FAIL full_hold full=%0b new=%0b exp=1/0", full_out, alu_new); end
        step();
        checks++; if (alu_new !== 1'b1 || alu_rob !== 4'd3 || full_out !== 1'b0) begin failures++; $display("FAIL order_c new=%0b rob=%0d full=%0b exp=1/3/0", alu_new, alu_rob, full_out); end
        step();
        checks++; if (alu_new !== 1'b1 || alu_rob !== 4'd4) begin failures++; $display("FAIL order_d new=%0b rob=%0d exp=1/4", alu_new, alu_rob); end
        cdb_valid = 1'b1; cdb_rob = 4'd8; cdb_value = 32'd77;
        step();
        cdb_valid = 1'b0;
        checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL full_ignored got=%0b exp=0", alu_new); end
        step();
        checks++; if (alu_new !== 1'b1 || alu_rob !== 4'd1 || alu_vi !== 32'd77) begin failures++; $display("FAIL order_a new=%0b rob=%0d vi=%0d exp=1/1/77", alu_new, alu_rob, alu_vi); end
        step();
        checks++; if (alu_new !== 1'b1 || alu_rob !== 4'd2 || alu_vj !== 32'd77) begin failures++; $display("FAIL order_b new=%0b rob=%0d vj=%0d exp=1/2/77", alu_new, alu_rob, alu_vj); end
        step();
        checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL order_empty got=%0b exp=0", alu_new); end
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_disp(BGE, 32'd0, 32'd1, 4'd12, 1'b1, 4'd0, 1'b0, 4'(6 + i));
            step();
        end
        checks++; if (full_out !== 1'b1) begin failures++; $display("FAIL clear_pre_full got=%0b exp=1", full_out); end
        clear_in = 1'b1;
        set_disp(BEQ, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10);
        cdb_valid = 1'b1; cdb_rob = 4'd12; cdb_value = 32'hC;
        step();
        clear_in = 1'b0; disp_valid = 1'b0;
        checks++; if (full_out !== 1'b0 || alu_new !== 1'b0) begin failures++; $display("FAIL clear_flush full=%0b new=%0b exp=0/0", full_out, alu_new); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL clear_no_issue cycle=%0d got=%0b rob=%0d exp=0", i, alu_new, alu_rob); end
        end
        cdb_valid = 1'b0;
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        set_disp(BLTU, 32'd1, 32'd2, 4'd0, 1'b0, 4'd0, 1'b0, 4'd13); step();
        set_disp(BGEU, 32'd3, 32'd4, 4'd0, 1'b0, 4'd0, 1'b0, 4'd14); step();
        disp_valid = 1'b0;
        checks++; if (alu_new !== 1'b1 || alu_rob !== 4'd13) begin failures++; $display("FAIL rdy_first new=%0b rob=%0d exp=1/13", alu_new, alu_rob); end
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (alu_new !== 1'b1 || alu_rob !== 4'd13 || full_out !== 1'b0) begin failures++; $display("FAIL rdy_frozen cycle=%0d new=%0b rob=%0d full=%0b exp=1/13/0", i, alu_new, alu_rob, full_out); end
        end
        rdy_in = 1'b1;
        step();
        checks++; if (alu_new !== 1'b1 || alu_rob !== 4'd14) begin failures++; $display("FAIL rdy_resume new=%0b rob=%0d exp=1/14", alu_new, alu_rob); end
        step();
        checks++; if (alu_new !== 1'b0) begin failures++; $display("FAIL rdy_drain got=%0b exp=0", alu_new); end
    endtask

    task automatic test_random();
        br_op_e ops[6] = '{BEQ, BNE, BLT, BGE, BLTU, BGEU};
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rdy_in   = ($urandom_range(0, 99) < 90);
            clear_in = ($urandom_range(0, 99) < 3);
            if (mq.size() < 4 && $urandom_range(0, 1) == 1) begin
                set_disp(ops[$urandom_range(0, 5)], $urandom, $urandom,
                         4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom));
            end else begin
                disp_valid = 1'b0;
            end
            cdb_valid = 1'($urandom_range(0, 1));
            cdb_rob   = 4'($urandom_range(0, 7));
            cdb_value = $urandom;
            step();
            checks++; if (alu_new !== exp_new) begin failures++; $display("FAIL rnd_new c=%0d got=%0b exp=%0b", c, alu_new, exp_new); end
            checks++; if (full_out !== (mq.size() == 4)) begin failures++; $display("FAIL rnd_full c=%0d got=%0b exp=%0b", c, full_out, mq.size() == 4); end
            checks++; if (alu_rob !== exp_rob || alu_op !== exp_op) begin failures++; $display("FAIL rnd_tag c=%0d rob=%0d op=%0b exp=%0d/%0b", c, alu_rob, alu_op, exp_rob, exp_op); end
            checks++; if (alu_vi !== exp_vi || alu_vj !== exp_vj) begin failures++; $display("FAIL rnd_vals c=%0d vi=%0h vj=%0h exp=%0h/%0h", c, alu_vi, alu_vj, exp_vi, exp_vj); end
            checks++; if (alu_imm !== exp_imm || alu_pc !== exp_pc) begin failures++; $display("FAIL rnd_immpc c=%0d imm=%0h pc=%0h exp=%0h/%0h", c, alu_imm, alu_pc, exp_imm, exp_pc); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_beq_ready();
        test_cdb_wakeup();
        test_cdb_bypass();
        test_full_order();
        test_clear();
        test_rdy_freeze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
